// File: rtl/hd8_and_sched_pkg.sv
// hd8_and_sched_pkg: shared types, schedule encoding helpers and operand evaluation for hd8_and_sched
package hd8_and_sched_pkg;
  localparam int NUM_STEPS = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  // 0..7 select x0..x7, 8..23 select t0..t15, anything above reads as constant 0
  typedef logic [4:0] src_t;
  typedef struct packed {
    src_t src_a;
    src_t src_b;
    logic inv;
  } operand_t;
  typedef struct packed {
    operand_t a;
    operand_t b;
  } step_t;
  localparam src_t SRC_C0 = 5'd31;
  function automatic src_t ts(input int unsigned i);
    return src_t'(i + 8);
  endfunction
  function automatic operand_t opnd(input src_t a, input src_t b, input logic inv);
    return '{src_a: a, src_b: b, inv: inv};
  endfunction
  function automatic logic src_val(input src_t s, input logic [7:0] x, input logic [15:0] t);
    logic [4:0] ti;
    ti = s - 5'd8;
    return (s < 5'd8) ? x[s[2:0]] : (s < 5'd24) ? t[ti[3:0]] : 1'b0;
  endfunction
  function automatic logic operand_val(input operand_t o, input logic [7:0] x, input logic [15:0] t);
    return src_val(o.src_a, x, t) ^ src_val(o.src_b, x, t) ^ o.inv;
  endfunction
endpackage

// File: rtl/hd8_and_sched_rom.sv
// hd8_sched_rom: fixed 16-step AND schedule for Y, step index to operand selects
import hd8_and_sched_pkg::*;
module hd8_sched_rom (
  input  logic [3:0] idx,
  output step_t      step
);
  // steps 0-3 build zk, 4-7 build ok, 8-9 z0&z1&z2, 10-12 none-of-ok, 13 maj core, 14-15 final
  always_comb begin
    step = '0;
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        step.a = opnd({2'b00, idx[1:0], 1'b0}, SRC_C0, 1'b1);
        step.b = opnd({2'b00, idx[1:0], 1'b1}, SRC_C0, 1'b1);
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        step.a = opnd({2'b00, idx[1:0], 1'b0}, SRC_C0, 1'b0);
        step.b = opnd({2'b00, idx[1:0], 1'b1}, SRC_C0, 1'b0);
      end
      4'd8: begin
        step.a = opnd(ts(0), SRC_C0, 1'b0);
        step.b = opnd(ts(1), SRC_C0, 1'b0);
      end
      4'd9: begin
        step.a = opnd(ts(8), SRC_C0, 1'b0);
        step.b = opnd(ts(2), SRC_C0, 1'b0);
      end
      4'd10: begin
        step.a = opnd(ts(4), SRC_C0, 1'b1);
        step.b = opnd(ts(5), SRC_C0, 1'b1);
      end
      4'd11: begin
        step.a = opnd(ts(10), SRC_C0, 1'b0);
        step.b = opnd(ts(6), SRC_C0, 1'b1);
      end
      4'd12: begin
        step.a = opnd(ts(11), SRC_C0, 1'b0);
        step.b = opnd(ts(7), SRC_C0, 1'b1);
      end
      4'd13: begin
        step.a = opnd(ts(0), ts(1), 1'b0);
        step.b = opnd(ts(0), ts(2), 1'b0);
      end
      4'd14: begin
        step.a = opnd(ts(3), ts(9), 1'b0);
        step.b = opnd(ts(12), SRC_C0, 1'b0);
      end
      default: begin
        step.a = opnd(ts(14), SRC_C0, 1'b0);
        step.b = opnd(ts(13), ts(0), 1'b0);
      end
    endcase
  end
endmodule

// File: rtl/hd8_and_sched.sv
// hd8_and_sched: evaluates Y over an 8-bit word through one shared AND unit; HD8_AND_SCHED_STATS_EN enables and_count
import hd8_and_sched_pkg::*;
module hd8_and_sched #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_a,
  output logic        op_b,
  input  logic        res_valid,
  input  logic        res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_y,
  output logic        err,
  output logic [31:0] and_count
);
  state_t      state;
  logic [7:0]  x;
  logic [15:0] scratch;
  logic [3:0]  step;
  logic [31:0] wait_cnt;
  logic [7:0]  ex;
  logic [15:0] et;
  logic [3:0]  es;
  step_t       st;
  logic        ea;
  logic        eb;
  logic        timeout_hit;
  hd8_sched_rom u_rom (.idx(es), .step(st));
  assign ex = (state == IDLE) ? in_x : x;
  assign es = (state == IDLE) ? 4'd0 : step + 4'd1;
  assign ea = operand_val(st.a, ex, et);
  assign eb = operand_val(st.b, ex, et);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
  // scratch as it will look after this cycle, so the next step's operands can be registered now
  always_comb begin
    et = (state == IDLE) ? '0 : scratch;
    if (state == WAIT) et[step] = res;
  end
  // schedule FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      scratch   <= '0;
      step      <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      op_valid  <= 1'b0;
      op_a      <= 1'b0;
      op_b      <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= in_x;
            scratch  <= '0;
            step     <= '0;
            in_ready <= 1'b0;
            op_valid <= 1'b1;
            op_a     <= ea;
            op_b     <= eb;
            state    <= ISSUE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            scratch <= et;
            if (step == 4'(NUM_STEPS - 1)) begin
              out_valid <= 1'b1;
              out_y     <= res;
              state     <= DONE;
            end else begin
              step     <= step + 4'd1;
              op_valid <= 1'b1;
              op_a     <= ea;
              op_b     <= eb;
              state    <= ISSUE;
            end
          end else if (timeout_hit) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_y     <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
  // sticky error: stray AND results or an AND unit that never answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((res_valid && state != WAIT) || (state == WAIT && !res_valid && timeout_hit)) err <= 1'b1;
  end
`ifdef HD8_AND_SCHED_STATS_EN
  logic [31:0] cnt;
  // accepted AND requests, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (op_valid && op_ready && cnt != '1) cnt <= cnt + 32'd1;
  end
  assign and_count = cnt;
`else
  assign and_count = '0;
`endif
endmodule

// File: tb/tb_hd8_and_sched.sv
// tb_hd8_and_sched: directed and random words against a formula model with an emulated AND unit
module tb_hd8_and_sched;
  localparam int unsigned TMO = 8;
`ifdef HD8_AND_SCHED_STATS_EN
  localparam int INC = 16;
`else
  localparam int INC = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_x = 8'h00;
  logic op_ready = 1'b0;
  logic res_valid = 1'b0;
  logic res = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, op_valid, op_a, op_b, out_valid, out_y, err;
  logic [31:0] and_count;
  int checks = 0;
  int failures = 0;
  int stall = 0;
  int delay = 1;
  bit drop_res = 1'b0;
  int pulse_req = 0;
  int stall_viol = 0;
  logic [31:0] exp_cnt = 0;

  hd8_and_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res(res),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .err(err), .and_count(and_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic y_ref(input logic [7:0] v);
    logic [3:0] z;
    logic any_o;
    int nz;
    any_o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      z[k] = ((v >> (2 * k)) & 8'd3) == 8'd0;
      any_o = any_o | (((v >> (2 * k)) & 8'd3) == 8'd3);
    end
    nz = int'(z[0]) + int'(z[1]) + int'(z[2]);
    return (z[3] ^ (z[0] & z[1] & z[2])) & !any_o & (nz >= 2);
  endfunction

  // AND unit: stalls op_ready for `stall` cycles, answers `delay` cycles after acceptance
  initial begin
    int ph = 0;
    int cnt = 0;
    int ack = 0;
    logic lat = 1'b0;
    logic sa = 1'b0;
    logic sb = 1'b0;
    forever begin
      @(posedge clk); #1;
      op_ready = 1'b0;
      res_valid = 1'b0;
      if (!rst_n) begin
        ph = 0;
        cnt = 0;
      end else if (pulse_req != ack) begin
        ack = pulse_req;
        res_valid = 1'b1;
        res = 1'b1;
      end else if (ph == 2) begin
        cnt++;
        if (cnt == delay && !drop_res) begin
          res_valid = 1'b1;
          res = lat;
          ph = 0;
          cnt = 0;
        end
      end else if (op_valid) begin
        if (ph == 1) begin
          if (op_a !== sa || op_b !== sb) stall_viol++;
        end else begin
          sa = op_a;
          sb = op_b;
        end
        if (cnt >= stall) begin
          op_ready = 1'b1;
          lat = op_a & op_b;
          ph = 2;
          cnt = 0;
        end else begin
          ph = 1;
          cnt++;
        end
      end
    end
  end

  task automatic start_word(input logic [7:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_x = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [7:0] v, input int st, input int dl, input int hold);
    int n;
    stall = st;
    delay = dl;
    out_ready = (hold == 0);
    start_word(v);
    chk("op_valid_c1", op_valid, 1);
    n = 1;
    while (!out_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 1 + 16 * (1 + st + dl));
    chk("out_y", out_y, y_ref(v));
    chk("in_ready_done", in_ready, 0);
    exp_cnt += INC;
    chk("and_count", and_count, exp_cnt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_y", out_y, y_ref(v));
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_err", err, 0);
    chk("rst_and_count", and_count, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    run_word(8'h10, 0, 1, 0);
    run_word(8'h40, 0, 1, 0);
    run_word(8'h00, 0, 1, 0);
    run_word(8'hC0, 0, 1, 0);
    run_word(8'h50, 0, 1, 0);
    run_word(8'h10, 3, 5, 0);
    run_word(8'h40, 3, 5, 0);
    run_word(8'hC3, 3, 5, 0);
    run_word(8'h10, 0, 1, 10);
    for (int v = 0; v < 256; v++) run_word(8'(v), 0, 1, 0);
    repeat (20) run_word(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    chk("op_stable_while_stalled", stall_viol, 0);
    stall = 0;
    delay = 1;
    out_ready = 1'b1;
    start_word(8'h10);
    repeat (14) @(posedge clk);
    #1;
    chk("mid_op_valid", op_valid, 1);
    chk("mid_and_count", and_count, exp_cnt + ((INC == 16) ? 7 : 0));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_op_valid", op_valid, 0);
    chk("mid_rst_op_a", op_a, 0);
    chk("mid_rst_op_b", op_b, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_y", out_y, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_and_count", and_count, 0);
    exp_cnt = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_mid_reset", in_ready, 1);
    run_word(8'h40, 0, 1, 0);
    run_word(8'h50, 0, 1, 0);
    pulse_req++;
    repeat (2) @(posedge clk);
    #1;
    chk("err_stray_res", err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    chk("idle_after_stray", in_ready, 1);
    #1 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("err_cleared", err, 0);
    drop_res = 1'b1;
    start_word(8'h10);
    repeat (8) @(posedge clk);
    #1;
    chk("timeout_err_early", err, 0);
    chk("timeout_busy", in_ready, 0);
    @(posedge clk); #1;
    chk("timeout_err", err, 1);
    chk("timeout_idle", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("timeout_no_out", seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
